// File: rtl/bnn_sequencer.sv
// bnn_sequencer: loads a serial binary image and steps the LAYER_1/2/3 state bus with a watchdog.
// Optional cycle counter on perf_cycles when BNN_SEQ_PERF_EN is defined.
module bnn_sequencer #(
  parameter int IMG_DIM = 28,
  parameter int LAYER_TIMEOUT = 4095,
  parameter int CLASS_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic pixel_in,
  input  logic pixel_valid,
  output logic pixel_ready,
  input  logic layer_one_done,
  input  logic layer_two_done,
  input  logic layer_three_done,
  input  logic [CLASS_W-1:0] class_in,
  output logic [2:0] state,
  output logic [IMG_DIM*IMG_DIM-1:0] pixels,
  output logic [CLASS_W-1:0] result_class,
  output logic result_valid,
  output logic timeout_err,
  output logic [15:0] perf_cycles
);
  localparam int N = IMG_DIM * IMG_DIM;
  localparam int CW = $clog2(N + 1);
  localparam int WW = $clog2(LAYER_TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] L1 = 3'b010;
  localparam logic [2:0] L2 = 3'b011;
  localparam logic [2:0] L3 = 3'b100;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wd;
  logic done;
  logic fin;
  assign pixel_ready = state == LOAD;
  assign done = state == L1 ? layer_one_done : state == L2 ? layer_two_done :
                state == L3 ? layer_three_done : 1'b0;
  assign fin = !abort && state == L3 && layer_three_done;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pixels <= '0;
      result_class <= '0;
      result_valid <= 1'b0;
      timeout_err <= 1'b0;
      cnt <= '0;
      wd <= '0;
    end else if (abort) begin
      state <= IDLE;
      result_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          result_valid <= 1'b0;
          timeout_err <= 1'b0;
          cnt <= '0;
          pixels <= '0;
        end
        LOAD: if (pixel_valid) begin
          pixels[cnt] <= pixel_in;
          cnt <= cnt + 1'b1;
          wd <= '0;
          if (cnt == CW'(N - 1)) state <= L1;
        end
        L1, L2, L3: if (done) begin
          wd <= '0;
          state <= state == L3 ? IDLE : state + 3'd1;
          if (state == L3) begin
            result_class <= class_in;
            result_valid <= 1'b1;
          end
        end else if (wd == WW'(LAYER_TIMEOUT - 1)) begin
          // the cycle on which the count reaches the limit is the last one in this layer
          state <= IDLE;
          timeout_err <= 1'b1;
        end else wd <= wd + 1'b1;
        default: state <= IDLE;
      endcase
`ifdef BNN_SEQ_PERF_EN
  logic [15:0] perf_cnt;
  logic [15:0] perf_nxt;
  assign perf_nxt = perf_cnt == 16'hFFFF ? perf_cnt : perf_cnt + 16'd1;
  always_ff @(posedge clk)
    if (rst) begin
      perf_cnt <= '0;
      perf_cycles <= '0;
    end else if (!abort && state == IDLE && start) begin
      perf_cnt <= '0;
      perf_cycles <= '0;
    end else begin
      if (state != IDLE) perf_cnt <= perf_nxt;
      if (fin) perf_cycles <= perf_nxt;
    end
`else
  assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: scenario tasks with a class scoreboard for bnn_sequencer.
module tb_bnn_sequencer;
  localparam int N = 784;
  logic clk = 1'b0;
  logic rst, start, abort, pixel_in, pixel_valid;
  logic layer_one_done, layer_two_done, layer_three_done;
  logic [3:0] class_in;
  logic pixel_ready;
  logic [2:0] state;
  logic [N-1:0] pixels;
  logic [3:0] result_class;
  logic result_valid, timeout_err;
  logic [15:0] perf_cycles;
  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [N-1:0] chk;
  logic [15:0] perf_exp;
  always #5 clk = ~clk;
  bnn_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .layer_one_done(layer_one_done),
    .layer_two_done(layer_two_done), .layer_three_done(layer_three_done), .class_in(class_in),
    .state(state), .pixels(pixels), .result_class(result_class), .result_valid(result_valid),
    .timeout_err(timeout_err), .perf_cycles(perf_cycles)
  );
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task load_img(input logic [N-1:0] img, input bit gap, output int cyc);
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      pixel_valid = 1'b1;
      pixel_in = img[k];
      tick;
      cyc++;
      if (gap && k < N - 1) begin
        pixel_valid = 1'b0;
        pixel_in = ~img[k];
        tick;
        cyc++;
      end
    end
    pixel_valid = 1'b0;
  endtask
  task run_layers(input logic [3:0] cls);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (state !== 3'd2 + 3'(l)) begin
          failures++;
          $display("FAIL layer_hold l=%0d c=%0d state=%b want=%b", l, c, state, 3'd2 + 3'(l));
        end
        tick;
      end
      layer_one_done = l == 0;
      layer_two_done = l == 1;
      layer_three_done = l == 2;
      class_in = cls;
      tick;
      layer_one_done = 1'b0;
      layer_two_done = 1'b0;
      layer_three_done = 1'b0;
      class_in = 4'd0;
    end
  endtask
  task check_result(input string nm);
    checks++;
    if (state !== 3'b000 || result_valid !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_end state=%b rv=%b te=%b want 000/1/0", nm, state, result_valid, timeout_err);
    end
    checks++;
    if (exp_q.size() == 0 || result_class !== exp_q[0]) begin
      failures++;
      $display("FAIL %s_class got=%0d qsize=%0d", nm, result_class, exp_q.size());
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask
  task test_reset;
    rst = 1'b1;
    start = 0; abort = 0; pixel_in = 0; pixel_valid = 0;
    layer_one_done = 0; layer_two_done = 0; layer_three_done = 0; class_in = 0;
    repeat (3) tick;
    checks++;
    if (state !== 3'b000 || pixels !== '0 || result_valid !== 1'b0 || timeout_err !== 1'b0 ||
        pixel_ready !== 1'b0 || result_class !== 4'd0 || perf_cycles !== 16'd0) begin
      failures++;
      $display("FAIL reset state=%b pix_nz=%b rv=%b te=%b rdy=%b rc=%0d perf=%0d", state,
               |pixels, result_valid, timeout_err, pixel_ready, result_class, perf_cycles);
    end
    rst = 1'b0;
    tick;
  endtask
  task test_checker;
    int cyc;
    do_start;
    checks++;
    if (state !== 3'b001 || pixel_ready !== 1'b1 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL chk_start state=%b rdy=%b rv=%b want 001/1/0", state, pixel_ready, result_valid);
    end
    exp_q.push_back(4'd7);
    load_img(chk, 1'b0, cyc);
    checks++;
    if (cyc != 784 || state !== 3'b010 || pixel_ready !== 1'b0) begin
      failures++;
      $display("FAIL chk_load cyc=%0d state=%b rdy=%b want 784/010/0", cyc, state, pixel_ready);
    end
    checks++;
    if (pixels !== chk) begin
      failures++;
      $display("FAIL chk_pixels got=%h want=%h", pixels, chk);
    end
    run_layers(4'd7);
    check_result("chk");
`ifdef BNN_SEQ_PERF_EN
    perf_exp = 16'd802;
`else
    perf_exp = 16'd0;
`endif
    checks++;
    if (perf_cycles !== perf_exp) begin
      failures++;
      $display("FAIL chk_perf got=%0d want=%0d", perf_cycles, perf_exp);
    end
  endtask
  task test_back_to_back_gapped;
    int cyc;
    do_start;
    checks++;
    if (state !== 3'b001 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_start state=%b rv=%b want 001/0", state, result_valid);
    end
    exp_q.push_back(4'd9);
    load_img(chk, 1'b1, cyc);
    checks++;
    if (cyc != 1567 || state !== 3'b010 || pixels !== chk) begin
      failures++;
      $display("FAIL gap_load cyc=%0d state=%b pix_ok=%b want 1567/010/1", cyc, state, pixels === chk);
    end
    run_layers(4'd9);
    check_result("gap");
  endtask
  task test_timeout;
    int cyc, n;
    logic [N-1:0] ones;
    ones = '1;
    do_start;
    load_img(ones, 1'b0, cyc);
    repeat (5) tick;
    layer_one_done = 1'b1;
    tick;
    layer_one_done = 1'b0;
    checks++;
    if (state !== 3'b011) begin
      failures++;
      $display("FAIL to_enter state=%b want=011", state);
    end
    n = 0;
    while (state === 3'b011 && n < 5000) begin
      tick;
      n++;
    end
    checks++;
    if (n != 4095) begin
      failures++;
      $display("FAIL to_cycles got=%0d want=4095", n);
    end
    checks++;
    if (state !== 3'b000 || timeout_err !== 1'b1 || result_valid !== 1'b0 || result_class !== 4'd9) begin
      failures++;
      $display("FAIL to_end state=%b te=%b rv=%b rc=%0d want 000/1/0/9", state, timeout_err,
               result_valid, result_class);
    end
  endtask
  task test_abort;
    int cyc;
    logic [N-1:0] img, exp_pix;
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (state !== 3'b000 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL ab_idle state=%b te=%b want 000/1", state, timeout_err);
    end
    do_start;
    checks++;
    if (state !== 3'b001 || timeout_err !== 1'b0 || pixels !== '0) begin
      failures++;
      $display("FAIL ab_start state=%b te=%b pix_nz=%b want 001/0/0", state, timeout_err, |pixels);
    end
    exp_pix = '0;
    for (int k = 0; k < N; k++) img[k] = 1'($urandom);
    img[100] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      exp_pix[k] = img[k];
      pixel_valid = 1'b1;
      pixel_in = img[k];
      tick;
    end
    pixel_in = img[100];
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    pixel_valid = 1'b0;
    checks++;
    if (state !== 3'b000 || result_valid !== 1'b0 || pixels !== exp_pix) begin
      failures++;
      $display("FAIL ab_partial state=%b rv=%b got=%h want=%h", state, result_valid, pixels, exp_pix);
    end
    do_start;
    checks++;
    if (state !== 3'b001 || pixels !== '0) begin
      failures++;
      $display("FAIL ab_clear state=%b pix=%h want 001/0", state, pixels);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    cyc = 0;
  endtask
  task test_done_order;
    int cyc;
    logic [N-1:0] img;
    for (int k = 0; k < N; k++) img[k] = 1'($urandom);
    do_start;
    exp_q.push_back(4'd3);
    load_img(img, 1'b0, cyc);
    layer_two_done = 1'b1;
    layer_three_done = 1'b1;
    class_in = 4'd12;
    for (int c = 0; c < 10; c++) begin
      tick;
      checks++;
      if (state !== 3'b010) begin
        failures++;
        $display("FAIL order_hold c=%0d state=%b want=010", c, state);
      end
    end
    layer_two_done = 1'b0;
    layer_three_done = 1'b0;
    layer_one_done = 1'b1;
    tick;
    layer_one_done = 1'b0;
    checks++;
    if (state !== 3'b011 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_l2 state=%b rv=%b want 011/0", state, result_valid);
    end
    layer_one_done = 1'b1;
    layer_three_done = 1'b1;
    repeat (3) tick;
    checks++;
    if (state !== 3'b011) begin
      failures++;
      $display("FAIL order_l2_hold state=%b want=011", state);
    end
    layer_one_done = 1'b0;
    layer_three_done = 1'b0;
    layer_two_done = 1'b1;
    tick;
    layer_two_done = 1'b0;
    layer_three_done = 1'b1;
    class_in = 4'd3;
    tick;
    layer_three_done = 1'b0;
    check_result("order");
    checks++;
    if (pixels !== img) begin
      failures++;
      $display("FAIL order_pixels got=%h want=%h", pixels, img);
    end
  endtask
  task test_mid_reset;
    int cyc;
    do_start;
    load_img(chk, 1'b0, cyc);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (state !== 3'b000 || pixels !== '0 || result_valid !== 1'b0 || result_class !== 4'd0 ||
        timeout_err !== 1'b0 || perf_cycles !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset state=%b pix_nz=%b rv=%b rc=%0d te=%b perf=%0d", state, |pixels,
               result_valid, result_class, timeout_err, perf_cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) chk[k] = 1'(((k / 28) + (k % 28)) & 1);
    test_reset;
    test_checker;
    test_back_to_back_gapped;
    test_timeout;
    test_abort;
    test_done_order;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
